// File: rtl/spi_frame_xcvr.sv
// SPI mode-0 frame transceiver. All SPI pins are oversampled in the clk domain:
// sck/cs/sdi pass through equal-depth synchronizers, so the sampled sdi stays
// aligned with the detected sck edge. One frame is FRAME_BITS long. A finished
// frame goes to a single-entry rx holding register with a valid/ready handshake.
module spi_frame_xcvr #(
  parameter int FRAME_BITS  = 336,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  sdi,
  output logic                  sdo,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sck_sync, cs_sync, sdi_sync;
  logic                    sck_s, cs_s, sdi_s;
  logic                    sck_d, cs_d;
  logic                    sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES:0]    settle_pipe;
  logic                    armed;
  logic                    start, finish;
  logic [CW-1:0]           bit_cnt;
  logic [FRAME_BITS-1:0]   rx_sr, tx_sr;
  logic                    commit;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // Input synchronizers plus one-clk delayed copies for edge detection.
  // cs idles deselected (1) so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sck_d    <= sck_s;
      cs_d     <= cs_s;
    end
  end

  // Frame starts are only allowed once cs has been seen high after reset, so a
  // reset released with cs already low cannot begin a frame mid-transfer.
  // settle_pipe waits until the synchronizer and delayed copy hold real pin data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_pipe <= '0;
      armed       <= 1'b0;
    end else begin
      settle_pipe <= {settle_pipe[SYNC_STAGES-1:0], 1'b1};
      if (settle_pipe[SYNC_STAGES] && cs_s && cs_d)
        armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: cs alone moves the FSM; sck edges never change state.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath. A cs edge in the same clk as an sck edge wins, and that
  // sck edge is dropped. Bits beyond FRAME_BITS only move the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
    end else if (start) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= tx_data;
    end else if (state == SHIFT && !cs_rise) begin
      if (sck_rise) begin
        if (bit_cnt < CNT_FULL) begin
          if (MSB_FIRST != 0) rx_sr <= {rx_sr[FRAME_BITS-2:0], sdi_s};
          else                rx_sr <= {sdi_s, rx_sr[FRAME_BITS-1:1]};
        end
        if (bit_cnt != CNT_SAT)
          bit_cnt <= bit_cnt + 1'b1;
      end else if (sck_fall) begin
        if (MSB_FIRST != 0) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        else                tx_sr <= {1'b0, tx_sr[FRAME_BITS-1:1]};
      end
    end
  end

  // A complete frame is taken if the holding register is free or being
  // drained this very cycle; otherwise it is dropped and flagged.
  assign commit = finish && (bit_cnt == CNT_FULL) && (!rx_valid || rx_ready);

  // Receive holding register, handshake and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= finish && (bit_cnt != CNT_FULL);
      if (commit) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (finish && (bit_cnt == CNT_FULL) && rx_valid && !rx_ready)
        overrun <= 1'b1;
    end
  end

  assign busy = (state == SHIFT);
  assign sdo  = busy & ((MSB_FIRST != 0) ? tx_sr[FRAME_BITS-1] : tx_sr[0]);

endmodule

// File: tb/tb_spi_frame_xcvr.sv
// Bench for spi_frame_xcvr: three instances (8-bit MSB-first, 8-bit LSB-first,
// 336-bit default). Stimulus pushes expected frames into per-instance queues;
// a negedge monitor pops and compares on every rx handshake.
module tb_spi_frame_xcvr;
  localparam int SS   = 2;
  localparam int MAXB = 336;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            sck_p[3], cs_p[3], sdi_p[3], rdy[3];
  logic            sdo_w[3], rxv[3], busy_w[3], ferr_w[3], ovr_w[3];
  logic [7:0]      tx8a, tx8b, rx8a, rx8b;
  logic [MAXB-1:0] tx336, rx336;
  logic [MAXB-1:0] rxd[3];

  assign rxd[0] = MAXB'(rx8a);
  assign rxd[1] = MAXB'(rx8b);
  assign rxd[2] = rx336;

  spi_frame_xcvr #(.FRAME_BITS(8), .SYNC_STAGES(SS), .MSB_FIRST(1)) u0 (
    .clk(clk), .reset_n(reset_n), .sck(sck_p[0]), .cs(cs_p[0]), .sdi(sdi_p[0]),
    .sdo(sdo_w[0]), .tx_data(tx8a), .rx_data(rx8a), .rx_valid(rxv[0]),
    .rx_ready(rdy[0]), .busy(busy_w[0]), .frame_err(ferr_w[0]), .overrun(ovr_w[0]));

  spi_frame_xcvr #(.FRAME_BITS(8), .SYNC_STAGES(SS), .MSB_FIRST(0)) u1 (
    .clk(clk), .reset_n(reset_n), .sck(sck_p[1]), .cs(cs_p[1]), .sdi(sdi_p[1]),
    .sdo(sdo_w[1]), .tx_data(tx8b), .rx_data(rx8b), .rx_valid(rxv[1]),
    .rx_ready(rdy[1]), .busy(busy_w[1]), .frame_err(ferr_w[1]), .overrun(ovr_w[1]));

  spi_frame_xcvr u2 (
    .clk(clk), .reset_n(reset_n), .sck(sck_p[2]), .cs(cs_p[2]), .sdi(sdi_p[2]),
    .sdo(sdo_w[2]), .tx_data(tx336), .rx_data(rx336), .rx_valid(rxv[2]),
    .rx_ready(rdy[2]), .busy(busy_w[2]), .frame_err(ferr_w[2]), .overrun(ovr_w[2]));

  int              errors = 0;
  int              checks = 0;
  logic [MAXB-1:0] exp_q[3][$];
  int              ferr_cnt[3];
  int              exp_ferr[3];
  logic            exp_ovr[3];
  int              fb_of[3]  = '{8, 8, 336};
  int              msb_of[3] = '{1, 0, 1};

  task automatic check(input string name, input logic [MAXB-1:0] got,
                       input logic [MAXB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: bit i of seq is the i-th bit on the wire.
  function automatic logic [MAXB-1:0] rx_word(input int inst, input logic [MAXB-1:0] seq);
    logic [MAXB-1:0] w = '0;
    for (int i = 0; i < fb_of[inst]; i++)
      if (msb_of[inst] != 0) w[fb_of[inst]-1-i] = seq[i];
      else                   w[i] = seq[i];
    return w;
  endfunction

  function automatic logic [MAXB-1:0] tx_seq(input int inst, input logic [MAXB-1:0] tx);
    logic [MAXB-1:0] s = '0;
    for (int i = 0; i < fb_of[inst]; i++)
      s[i] = (msb_of[inst] != 0) ? tx[fb_of[inst]-1-i] : tx[i];
    return s;
  endfunction

  function automatic logic [MAXB-1:0] rev8(input logic [7:0] w);
    logic [MAXB-1:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  function automatic logic [MAXB-1:0] rand_bits();
    logic [MAXB-1:0] r;
    for (int i = 0; i < MAXB; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ferr_w[i]) ferr_cnt[i]++;
      if (reset_n && rxv[i] && rdy[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx%0d: got frame %0h expected none", i, rxd[i]);
        end else begin
          check($sformatf("rx_data%0d", i), rxd[i], exp_q[i].pop_front());
        end
      end
    end
  end

  // Master side at 4 clk per sck period; sdo sampled at the end of each high phase.
  task automatic spi_bits(input int inst, input logic [MAXB-1:0] seq, input int n,
                          output logic [MAXB-1:0] got_sdo);
    got_sdo = '0;
    cs_p[inst]  = 1'b0;
    sdi_p[inst] = seq[0];
    wait_clk(2);
    for (int i = 0; i < n; i++) begin
      sck_p[inst] = 1'b1;
      wait_clk(2);
      got_sdo[i]  = sdo_w[inst];
      sck_p[inst] = 1'b0;
      sdi_p[inst] = (i + 1 < n) ? seq[i+1] : 1'b0;
      wait_clk(2);
    end
    check($sformatf("busy%0d", inst), MAXB'(busy_w[inst]), MAXB'(1));
  endtask

  task automatic frame(input int inst, input logic [MAXB-1:0] seq, input int n,
                       input logic [MAXB-1:0] tx, input bit lat_chk);
    logic [MAXB-1:0] got, mask;
    int fb;
    fb = fb_of[inst];
    if (inst == 0)      tx8a  = tx[7:0];
    else if (inst == 1) tx8b  = tx[7:0];
    else                tx336 = tx;
    wait_clk(1);
    spi_bits(inst, seq, n, got);
    if (n == fb) begin
      if (exp_q[inst].size() == 0 || rdy[inst]) exp_q[inst].push_back(rx_word(inst, seq));
      else exp_ovr[inst] = 1'b1;
    end else begin
      exp_ferr[inst]++;
    end
    cs_p[inst] = 1'b1;
    if (lat_chk) begin
      // cs changes just after edge 1; rx_valid must appear at edge SS+2.
      wait_clk(SS);
      check("rx_valid_early", MAXB'(rxv[inst]), MAXB'(0));
      wait_clk(1);
      check("rx_valid_latency", MAXB'(rxv[inst]), MAXB'(1));
    end
    wait_clk(8);
    mask = (n < fb) ? ((MAXB'(1) << n) - MAXB'(1)) : ((MAXB'(1) << fb) - MAXB'(1));
    check($sformatf("sdo%0d", inst), got & mask, tx_seq(inst, tx) & mask);
    check($sformatf("frame_err_count%0d", inst), MAXB'(ferr_cnt[inst]), MAXB'(exp_ferr[inst]));
    check($sformatf("overrun%0d", inst), MAXB'(ovr_w[inst]), MAXB'(exp_ovr[inst]));
    check($sformatf("idle%0d", inst), MAXB'(busy_w[inst]), MAXB'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [MAXB-1:0] junk;
    for (int i = 0; i < 3; i++) begin
      sck_p[i] = 1'b0; cs_p[i] = 1'b1; sdi_p[i] = 1'b0; rdy[i] = 1'b1;
      exp_ovr[i] = 1'b0;
    end
    tx8a = '0; tx8b = '0; tx336 = '0;
    reset_n = 1'b0;
    wait_clk(3);
    for (int i = 0; i < 3; i++) begin
      check("rst_rx_valid", MAXB'(rxv[i]), MAXB'(0));
      check("rst_busy", MAXB'(busy_w[i]), MAXB'(0));
      check("rst_frame_err", MAXB'(ferr_w[i]), MAXB'(0));
      check("rst_overrun", MAXB'(ovr_w[i]), MAXB'(0));
      check("rst_sdo", MAXB'(sdo_w[i]), MAXB'(0));
      check("rst_rx_data", rxd[i], '0);
    end
    reset_n = 1'b1;
    wait_clk(6);

    // 0xA5 MSB first in, 0x3C out; LSB-first wire order 1,0,1,0,0,1,0,1 -> 0xA5.
    frame(0, rev8(8'hA5), 8, MAXB'(8'h3C), 1'b1);
    check("sdo_3c_pattern", tx_seq(0, MAXB'(8'h3C)), MAXB'(8'b0011_1100));
    frame(1, MAXB'(8'b1010_0101), 8, MAXB'(8'h01), 1'b1);

    for (int k = 0; k < 4; k++) frame(0, rand_bits(), 8, rand_bits(), 1'b0);
    for (int k = 0; k < 3; k++) frame(1, rand_bits(), 8, rand_bits(), 1'b0);

    // Overrun: second frame dropped while the first is unconsumed.
    rdy[0] = 1'b0;
    frame(0, rev8(8'h11), 8, rand_bits(), 1'b0);
    frame(0, rev8(8'h22), 8, rand_bits(), 1'b0);
    check("held_rx_data", MAXB'(rx8a), MAXB'(8'h11));
    check("held_rx_valid", MAXB'(rxv[0]), MAXB'(1));
    rdy[0] = 1'b1;
    wait_clk(1);
    check("rx_valid_clear", MAXB'(rxv[0]), MAXB'(0));
    wait_clk(2);

    // Short and long frames.
    frame(0, rand_bits(), 5, rand_bits(), 1'b0);
    frame(0, rand_bits(), 9, rand_bits(), 1'b0);
    check("bad_frames_no_valid", MAXB'(rxv[0]), MAXB'(0));

    // Reset mid-frame, released with cs low.
    spi_bits(0, rand_bits(), 4, junk);
    reset_n = 1'b0;
    wait_clk(2);
    for (int i = 0; i < 3; i++) exp_ovr[i] = 1'b0;
    check("mid_rst_overrun", MAXB'(ovr_w[0]), MAXB'(0));
    check("mid_rst_busy", MAXB'(busy_w[0]), MAXB'(0));
    reset_n = 1'b1;
    wait_clk(8);
    check("no_start_cs_low", MAXB'(busy_w[0]), MAXB'(0));
    cs_p[0] = 1'b1;
    wait_clk(8);
    check("post_rst_rx_valid", MAXB'(rxv[0]), MAXB'(0));
    check("post_rst_frame_err", MAXB'(ferr_cnt[0]), MAXB'(exp_ferr[0]));
    frame(0, rev8(8'h5A), 8, rand_bits(), 1'b1);

    // Full-size frames at f_clk = 4 x f_sck.
    frame(2, rand_bits(), 336, rand_bits(), 1'b1);
    frame(2, rand_bits(), 336, rand_bits(), 1'b0);

    wait_clk(10);
    for (int i = 0; i < 3; i++)
      check($sformatf("drain%0d", i), MAXB'(exp_q[i].size()), MAXB'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_frame_xcvr.md
SPI_FRAME_XCVR -- requirements
Module: spi_frame_xcvr

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 336, giving the bits per frame (range 8..1024).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sck/cs/sdi (range 2..3).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = MSB first on sdi/sdo, 0 = LSB first.
REQ-004 clk  in  1  system clock; all state on rising edge; one clock.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 sck  in  1  SPI clock, mode 0, asynchronous to clk.
REQ-007 cs  in  1  chip select, high = deselected; frame runs while low.
REQ-008 sdi  in  1  serial data in.
REQ-009 sdo  out  1  serial data out.
REQ-010 tx_data  in  FRAME_BITS  response frame; captured at frame start.
REQ-011 rx_data  out  FRAME_BITS  last complete received frame, held.
REQ-012 rx_valid  out  1  rx_data holds an unconsumed frame.
REQ-013 rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-014 busy  out  1  frame in progress (state SHIFT).
REQ-015 frame_err  out  1  one-clk pulse: frame ended with bit count != FRAME_BITS.
REQ-016 overrun  out  1  sticky: complete frame dropped because rx_valid was still high.

Function
REQ-017 SHALL pass sck, cs and sdi through SYNC_STAGES flops each; sck/cs sync flops SHALL reset to 0/1 respectively.
REQ-018 SHALL detect edges by comparing the last sync stage with a one-clk-delayed copy; all actions SHALL register on the same clk edge as detection.
REQ-019 SHALL support correct operation only for f_clk >= 4 x f_sck; the design SHALL NOT use sck as a clock.
REQ-020 SHALL implement states IDLE and SHIFT; IDLE -> SHIFT on cs falling; SHIFT -> IDLE on cs rising.
REQ-021 On IDLE->SHIFT: bit counter cleared to 0, tx shift register loaded from tx_data, busy = 1.
REQ-022 In SHIFT, on sck rising: sample synced sdi into the rx shift register (shift left with sdi at LSB if MSB_FIRST, else shift right with sdi at MSB); counter increments, saturating at FRAME_BITS+1.
REQ-023 Edges after counter = FRAME_BITS SHALL NOT modify the rx shift register.
REQ-024 sdo SHALL present tx bit FRAME_BITS-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0) from the load; on each sck falling in SHIFT the tx register SHALL shift, presenting the next bit; sdo = 0 in IDLE.
REQ-025 On SHIFT->IDLE with counter == FRAME_BITS: if rx_valid = 0, or rx_valid & rx_ready in that cycle, rx_data <= rx shift register and rx_valid <= 1.
REQ-026 Same case with rx_valid = 1 and rx_ready = 0: frame dropped, rx_data unchanged, overrun <= 1.
REQ-027 On SHIFT->IDLE with counter != FRAME_BITS: frame_err = 1 for exactly one clk; rx_data, rx_valid unchanged.
REQ-028 rx_valid SHALL clear on the clk after rx_valid & rx_ready unless REQ-025 reloads it in that same cycle.
REQ-029 overrun SHALL clear only on reset.
REQ-030 Latency: rx_valid rises SYNC_STAGES+2 clk edges after cs pin rises (stable input).
REQ-031 cs and sck edges detected in the same clk SHALL give cs priority; that sck edge is ignored.

Reset
REQ-032 While reset_n = 0: state IDLE, counter 0, shift registers 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, overrun 0, sdo 0.
REQ-033 Reset asserted mid-frame SHALL abort it with no rx_valid/frame_err; after release with cs already low, no frame starts until cs rises and falls again.

Verification
REQ-034 FRAME_BITS=8, MSB_FIRST=1: send 0xA5, tx_data=0x3C -> sdo bits 0,0,1,1,1,1,0,0; rx_data=0xA5, rx_valid=1 at SYNC_STAGES+2 clks after cs rise.
REQ-035 MSB_FIRST=0: send bit sequence 1,0,1,0,0,1,0,1 -> rx_data=0xA5; tx_data=0x01 -> first sdo bit 1.
REQ-036 Two 8-bit frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, overrun=1; raise rx_ready -> rx_valid clears next clk.
REQ-037 Frame of 5 clocks, then frame of 9 clocks -> frame_err one-clk pulse each, rx_valid stays 0.
REQ-038 reset_n low after 4 bits, released with cs low, cs raised -> no rx_valid, no frame_err; next full frame 0x5A received correctly.
REQ-039 FRAME_BITS=336 default, random 42-byte payload at f_clk = 4 x f_sck -> rx_data matches bit-exact.
